aes_key_store: RTL and testbench

//  Multi-slot AES key store, the parametrised successor of the single 128-bit key register.

---
 rtl/aes_key_pkg.sv | 29 ++
 rtl/aes_key_slot.sv | 90 +++++++++
 rtl/aes_key_store.sv | 247 ++++++++++++++++++++++++
 tb/tb_aes_key_store.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the multi-slot AES key store.
package aes_key_pkg;

  // Full key storage width; shorter keys are zero-extended into it.
  localparam int unsigned KeyW = 256;

  typedef enum logic [1:0] {
    AES_128 = 2'd0,
    AES_192 = 2'd1,
    AES_256 = 2'd2
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ZERO = 2'd2
  } key_store_state_e;

  // Number of load words that make up a key of the given length.
  function automatic int unsigned key_words(key_len_e len, int word_w);
    case (len)
      AES_128: return 128 / word_w;
      AES_192: return 192 / word_w;
      AES_256: return 256 / word_w;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_slot.sv
// One key slot: key storage plus valid, locked and length flags.
module aes_key_slot
  import aes_key_pkg::*;
#(
  parameter int WordW    = 32,
  parameter bit ResetAll = 1'b0,
  parameter int IdxW     = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            zero_i,
  input  logic [1:0]      len_i,
  input  logic            word_we_i,
  input  logic [IdxW-1:0] word_idx_i,
  input  logic [WordW-1:0] word_i,
  input  logic            set_valid_i,
  input  logic            lock_i,
  output logic [KeyW-1:0] key_o,
  output logic [1:0]      len_o,
  output logic            valid_o,
  output logic            locked_o
);

  localparam int NumWords = KeyW / WordW;

  logic [KeyW-1:0] key_q, key_d;
  logic [1:0]      len_q;
  logic            valid_q, locked_q;

  // Next key value: clearing wins, otherwise drop the incoming word into its lane.
  always_comb begin
    key_d = key_q;
    if (zero_i || clear_i) begin
      key_d = '0;
    end else if (word_we_i) begin
      for (int w = 0; w < NumWords; w++) begin
        if (word_idx_i == IdxW'(w)) begin
          key_d[w*WordW +: WordW] = word_i;
        end
      end
    end
  end

  if (ResetAll) begin : g_key_rst
    // Key storage with reset, for builds that want a known key after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        key_q <= '0;
      end else begin
        key_q <= key_d;
      end
    end
  end else begin : g_key_nrst
    // Key storage without reset; the valid flag guards its meaning.
    always_ff @(posedge clk_i) begin
      key_q <= key_d;
    end
  end

  // Slot flags; zeroize clears everything including the lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      len_q    <= 2'd0;
    end else if (zero_i) begin
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      len_q    <= 2'd0;
    end else begin
      if (clear_i) begin
        valid_q <= 1'b0;
        len_q   <= len_i;
      end
      if (set_valid_i) begin
        valid_q <= 1'b1;
      end
      if (lock_i) begin
        locked_q <= 1'b1;
      end
    end
  end

  assign key_o    = key_q;
  assign len_o    = len_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/aes_key_store.sv
// Multi-slot AES key store: word-serial loading, per-slot lock, sweep zeroization
// and a registered read port for the cipher cores.
module aes_key_store
  import aes_key_pkg::*;
#(
  parameter int NumSlots = 4,
  parameter int WordW    = 32,
  parameter bit ResetAll = 1'b0,
  localparam int SlotW   = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic [SlotW-1:0] load_slot_i,
  input  logic [1:0]       load_len_i,
  input  logic             word_valid_i,
  input  logic [WordW-1:0] word_i,
  output logic             word_ready_o,
  input  logic             lock_i,
  input  logic [SlotW-1:0] lock_slot_i,
  input  logic             zeroize_i,
  output logic             busy_o,
  output logic             err_o,
  input  logic [SlotW-1:0] rd_slot_i,
  output logic [255:0]     key_o,
  output logic [1:0]       key_len_o,
  output logic             key_valid_o,
  output logic             key_locked_o
);

  localparam int MaxWords = KeyW / WordW;
  localparam int CntW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;

  localparam int unsigned Words128 = key_words(AES_128, WordW);
  localparam int unsigned Words192 = key_words(AES_192, WordW);
  localparam int unsigned Words256 = key_words(AES_256, WordW);

  localparam logic [CntW-1:0] Last128 = CntW'(Words128 - 1);
  localparam logic [CntW-1:0] Last192 = CntW'(Words192 - 1);
  localparam logic [CntW-1:0] Last256 = CntW'(Words256 - 1);

  key_store_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  last_q, last_d;
  logic [SlotW-1:0] load_slot_q, load_slot_d;
  logic [SlotW-1:0] zptr_q, zptr_d;
  logic             err_q, err_d;

  logic start_ok, word_acc, lock_ok;
  logic ld_in_range, ld_locked, lk_in_range;

  logic [KeyW-1:0] slot_key    [NumSlots];
  logic [1:0]      slot_len    [NumSlots];
  logic            slot_valid  [NumSlots];
  logic            slot_locked [NumSlots];

  logic [KeyW-1:0] rd_key;
  logic [1:0]      rd_len;
  logic            rd_valid, rd_locked;

  logic [KeyW-1:0] key_q;
  logic [1:0]      key_len_q;
  logic            key_valid_q, key_locked_q;

  // Decode slot indices against the populated slots; out-of-range indices match nothing.
  always_comb begin
    ld_in_range = 1'b0;
    ld_locked   = 1'b0;
    lk_in_range = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (load_slot_i == SlotW'(s)) begin
        ld_in_range = 1'b1;
        ld_locked   = slot_locked[s];
      end
      if (lock_slot_i == SlotW'(s)) begin
        lk_in_range = 1'b1;
      end
    end
  end

  // Next-state, command acceptance and error decisions; zeroize overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    load_slot_d = load_slot_q;
    zptr_d      = zptr_q;
    err_d       = 1'b0;
    start_ok    = 1'b0;
    word_acc    = 1'b0;
    lock_ok     = 1'b0;

    if (zeroize_i) begin
      state_d = ST_ZERO;
      zptr_d  = '0;
    end else begin
      if (load_start_i) begin
        if (state_q == ST_IDLE && ld_in_range && !ld_locked && load_len_i != 2'd3) begin
          start_ok    = 1'b1;
          state_d     = ST_LOAD;
          cnt_d       = '0;
          load_slot_d = load_slot_i;
          case (load_len_i)
            2'd0:    last_d = Last128;
            2'd1:    last_d = Last192;
            default: last_d = Last256;
          endcase
        end else begin
          err_d = 1'b1;
        end
      end

      if (lock_i) begin
        if (state_q != ST_ZERO && lk_in_range) begin
          lock_ok = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      case (state_q)
        ST_LOAD: begin
          if (word_valid_i) begin
            word_acc = 1'b1;
            if (cnt_q == last_q) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_ZERO: begin
          if (zptr_q == SlotW'(NumSlots - 1)) begin
            state_d = ST_IDLE;
          end else begin
            zptr_d = zptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers: FSM state, word counter, target slot, sweep pointer, error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      load_slot_q <= '0;
      zptr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      load_slot_q <= load_slot_d;
      zptr_q      <= zptr_d;
      err_q       <= err_d;
    end
  end

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    logic sel_clear, sel_zero, sel_word, sel_valid, sel_lock;

    assign sel_clear = start_ok && (load_slot_i == SlotW'(s));
    assign sel_zero  = (state_q == ST_ZERO) && (zptr_q == SlotW'(s));
    assign sel_word  = word_acc && (load_slot_q == SlotW'(s));
    assign sel_valid = sel_word && (cnt_q == last_q);
    assign sel_lock  = lock_ok && (lock_slot_i == SlotW'(s));

    aes_key_slot #(
      .WordW   (WordW),
      .ResetAll(ResetAll),
      .IdxW    (CntW)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (sel_clear),
      .zero_i     (sel_zero),
      .len_i      (load_len_i),
      .word_we_i  (sel_word),
      .word_idx_i (cnt_q),
      .word_i     (word_i),
      .set_valid_i(sel_valid),
      .lock_i     (sel_lock),
      .key_o      (slot_key[s]),
      .len_o      (slot_len[s]),
      .valid_o    (slot_valid[s]),
      .locked_o   (slot_locked[s])
    );
  end

  // Read select mux; an unpopulated slot index reads as an empty slot.
  always_comb begin
    rd_key    = '0;
    rd_len    = 2'd0;
    rd_valid  = 1'b0;
    rd_locked = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (rd_slot_i == SlotW'(s)) begin
        rd_key    = slot_key[s];
        rd_len    = slot_len[s];
        rd_valid  = slot_valid[s];
        rd_locked = slot_locked[s];
      end
    end
  end

  // Registered read flags, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_len_q    <= 2'd0;
      key_valid_q  <= 1'b0;
      key_locked_q <= 1'b0;
    end else begin
      key_len_q    <= rd_len;
      key_valid_q  <= rd_valid;
      key_locked_q <= rd_locked;
    end
  end

  if (ResetAll) begin : g_rd_rst
    // Registered read key, reset along with the storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        key_q <= '0;
      end else begin
        key_q <= rd_key;
      end
    end
  end else begin : g_rd_nrst
    // Registered read key, unreset like the storage behind it.
    always_ff @(posedge clk_i) begin
      key_q <= rd_key;
    end
  end

  assign key_o        = key_q;
  assign key_len_o    = key_len_q;
  assign key_valid_o  = key_valid_q;
  assign key_locked_o = key_locked_q;
  assign word_ready_o = (state_q == ST_LOAD);
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_aes_key_store.sv
// Scoreboard bench for aes_key_store: stimulus pushes expectations, a negedge monitor checks them.
module tb_aes_key_store;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         load_start_i;
  logic [1:0]   load_slot_i;
  logic [1:0]   load_len_i;
  logic         word_valid_i;
  logic [31:0]  word_i;
  logic         word_ready_o;
  logic         lock_i;
  logic [1:0]   lock_slot_i;
  logic         zeroize_i;
  logic         busy_o;
  logic         err_o;
  logic [1:0]   rd_slot_i;
  logic [255:0] key_o;
  logic [1:0]   key_len_o;
  logic         key_valid_o;
  logic         key_locked_o;

  localparam logic [255:0] K128  = 256'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [255:0] K256  = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] K1    = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [255:0] K2    = 256'h13579BDF_2468ACE0_FFFF0000_0000FFFF;
  localparam logic [255:0] K192  = 256'hAAAA0005_AAAA0004_AAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [255:0] K256B = 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;

  localparam int KRead  = 0;
  localparam int KErr   = 1;
  localparam int KBusy  = 2;
  localparam int KReady = 3;

  typedef struct {
    int           due;
    int           kind;
    string        name;
    logic [255:0] key;
    logic [1:0]   len;
    logic         valid;
    logic         locked;
    bit           chk_key;
    logic         val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  aes_key_store #(
    .NumSlots(4),
    .WordW   (32),
    .ResetAll(1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_start_i(load_start_i),
    .load_slot_i (load_slot_i),
    .load_len_i  (load_len_i),
    .word_valid_i(word_valid_i),
    .word_i      (word_i),
    .word_ready_o(word_ready_o),
    .lock_i      (lock_i),
    .lock_slot_i (lock_slot_i),
    .zeroize_i   (zeroize_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .rd_slot_i   (rd_slot_i),
    .key_o       (key_o),
    .key_len_o   (key_len_o),
    .key_valid_o (key_valid_o),
    .key_locked_o(key_locked_o)
  );

  // Free-running clock and cycle counter used to time expectations.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Queue a read expectation; lag 1 means the response after the next edge.
  task automatic check_output(input int slot, input logic [255:0] key, input logic [1:0] len,
                              input logic valid, input logic locked, input bit chk_key,
                              input int lag, input string name);
    exp_t e;
    rd_slot_i = 2'(slot);
    e.due = cyc + lag; e.kind = KRead; e.name = name; e.key = key; e.len = len;
    e.valid = valid; e.locked = locked; e.chk_key = chk_key; e.val = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic expect_sig(input int kind, input logic val, input int lag, input string name);
    exp_t e;
    e.due = cyc + lag; e.kind = kind; e.name = name; e.key = '0; e.len = 2'd0;
    e.valid = 1'b0; e.locked = 1'b0; e.chk_key = 1'b0; e.val = val;
    sb_q.push_back(e);
  endtask

  // Issue one single-cycle command and queue its expected error response.
  task automatic apply_stimulus(input logic start, input logic [1:0] slot, input logic [1:0] len,
                                input logic lock, input logic [1:0] lslot, input logic zero,
                                input logic exp_err, input string name);
    load_start_i = start; load_slot_i = slot; load_len_i = len;
    lock_i = lock; lock_slot_i = lslot; zeroize_i = zero;
    expect_sig(KErr, exp_err, 1, name);
    tick();
    load_start_i = 1'b0; lock_i = 1'b0; zeroize_i = 1'b0;
  endtask

  // Stream words lo..hi-1 of data, optionally with an idle cycle between words.
  task automatic load_words(input logic [255:0] data, input int lo, input int hi,
                            input bit gap, input bit done, input string name);
    for (int i = lo; i < hi; i++) begin
      expect_sig(KBusy, 1'b1, 0, {name, "_busy"});
      expect_sig(KReady, 1'b1, 0, {name, "_ready"});
      word_valid_i = 1'b1;
      word_i = data[i*32 +: 32];
      tick();
      word_valid_i = 1'b0;
      if (gap && i < hi - 1) tick();
    end
    if (done) begin
      expect_sig(KBusy, 1'b0, 0, {name, "_done_busy"});
      expect_sig(KReady, 1'b0, 0, {name, "_done_ready"});
    end
  endtask

  task automatic compare(input exp_t e);
    logic act;
    n_vec++;
    if (e.kind == KRead) begin
      if (key_valid_o !== e.valid || key_len_o !== e.len || key_locked_o !== e.locked ||
          (e.chk_key && key_o !== e.key)) begin
        n_fail++;
        $display("[TB] FAIL %s: got valid=%b len=%0d locked=%b key=%h, expected valid=%b len=%0d locked=%b key=%h",
                 e.name, key_valid_o, key_len_o, key_locked_o, key_o, e.valid, e.len, e.locked, e.key);
      end
    end else begin
      case (e.kind)
        KErr:    act = err_o;
        KBusy:   act = busy_o;
        default: act = word_ready_o;
      endcase
      if (act !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: got %b, expected %b", e.name, act, e.val);
      end
    end
  endtask

  // Monitor: compare every queued expectation that falls due in this cycle.
  always @(negedge clk_i) begin
    int i;
    exp_t e;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due <= cyc) begin
        e = sb_q[i];
        sb_q.delete(i);
        compare(e);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    load_start_i = 1'b0; load_slot_i = 2'd0; load_len_i = 2'd0;
    word_valid_i = 1'b0; word_i = '0; lock_i = 1'b0; lock_slot_i = 2'd0;
    zeroize_i = 1'b0; rd_slot_i = 2'd0;
    $display("[TB] start");

    repeat (2) tick();
    expect_sig(KBusy, 1'b0, 0, "reset_busy");
    expect_sig(KReady, 1'b0, 0, "reset_ready");
    expect_sig(KErr, 1'b0, 0, "reset_err");
    check_output(0, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1, "reset_read");
    tick();
    rst_ni = 1'b1;
    tick();

    // 128-bit load into slot 0
    apply_stimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "t1_start");
    load_words(K128, 0, 4, 1'b0, 1'b1, "t1");
    check_output(0, K128, 2'd0, 1'b1, 1'b0, 1'b1, 1, "t1_read");
    tick();

    // 256-bit load into slot 3 with a bubble between words
    apply_stimulus(1'b1, 2'd3, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, "t2_start");
    load_words(K256, 0, 8, 1'b1, 1'b1, "t2");
    check_output(3, K256, 2'd2, 1'b1, 1'b0, 1'b1, 1, "t2_read");
    tick();

    // lock slot 0, then a load to it is rejected
    apply_stimulus(1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, "t3_lock");
    apply_stimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, "t3_start_locked");
    expect_sig(KErr, 1'b0, 1, "t3_err_pulse_end");
    expect_sig(KBusy, 1'b0, 0, "t3_busy");
    check_output(0, K128, 2'd0, 1'b1, 1'b1, 1'b1, 1, "t3_read");
    tick();

    // invalid length rejected in IDLE
    apply_stimulus(1'b1, 2'd1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, "t5_len3");
    expect_sig(KBusy, 1'b0, 0, "t5_len3_busy");

    // load slot 1; mid-load a second start is rejected while a lock of slot 1 lands
    apply_stimulus(1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "t5_start");
    load_words(K1, 0, 2, 1'b0, 1'b0, "t5a");
    apply_stimulus(1'b1, 2'd2, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, "t5_start_in_load");
    load_words(K1, 2, 4, 1'b0, 1'b1, "t5b");
    check_output(1, K1, 2'd0, 1'b1, 1'b1, 1'b1, 1, "t5_read_slot1");
    tick();
    check_output(2, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1, "t5_read_slot2");
    tick();

    // start and lock of the same slot together: load proceeds, lock applies
    apply_stimulus(1'b1, 2'd2, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, "t6_start_lock");
    load_words(K2, 0, 4, 1'b0, 1'b1, "t6");
    check_output(2, K2, 2'd0, 1'b1, 1'b1, 1'b1, 1, "t6_read");
    tick();

    // zeroize after 3 of 6 words of a 192-bit load
    apply_stimulus(1'b1, 2'd3, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, "t4_start");
    load_words(K192, 0, 3, 1'b0, 1'b0, "t4");
    apply_stimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, "t4_zeroize");
    expect_sig(KBusy, 1'b1, 0, "t4_busy_z0");
    expect_sig(KReady, 1'b0, 0, "t4_ready_z0");
    tick();
    expect_sig(KBusy, 1'b1, 0, "t4_busy_z1");
    apply_stimulus(1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, "t4_lock_in_zero");
    expect_sig(KBusy, 1'b1, 0, "t4_busy_z2");
    apply_stimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, "t4_start_in_zero");
    expect_sig(KBusy, 1'b1, 0, "t4_busy_z3");
    tick();
    expect_sig(KBusy, 1'b0, 0, "t4_busy_after");
    for (int s = 0; s < 4; s++) begin
      check_output(s, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1, $sformatf("t4_read_slot%0d", s));
      tick();
    end

    // reset in the middle of a load
    apply_stimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "t7_start");
    load_words(K128, 0, 2, 1'b0, 1'b0, "t7");
    rst_ni = 1'b0;
    #1;
    expect_sig(KReady, 1'b0, 0, "t7_rst_ready");
    expect_sig(KBusy, 1'b0, 0, "t7_rst_busy");
    check_output(0, '0, 2'd0, 1'b0, 1'b0, 1'b0, 0, "t7_rst_read");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      check_output(s, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1, $sformatf("t7_read_slot%0d", s));
      tick();
    end
    apply_stimulus(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, "t7_fresh_start");
    load_words(K256B, 0, 8, 1'b0, 1'b1, "t7_fresh");
    check_output(0, K256B, 2'd2, 1'b1, 1'b0, 1'b1, 1, "t7_fresh_read");

    repeat (4) tick();
    while (sb_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL %s: got no sample, expected check at cycle %0d", sb_q[0].name, sb_q[0].due);
      void'(sb_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
